// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller
//   Bridges single AHB-side transfers onto an APB bus. Each accepted transfer
//   runs as an APB SETUP phase followed by one or more ACCESS phases. Writes
//   take one extra cycle (WWAIT) to capture the AHB data-phase write data.
//   Slave errors, wait-state timeouts and accesses with no decoded slave are
//   returned to the AHB side as a two-cycle ERROR response (ERR1, ERR2).
//   Only one APB transfer is in flight; hready_out stalls the AHB side.
//
// Ports
//   hclk, hresetn      clock (rising edge), asynchronous active-low reset
//   valid              AHB address phase holds a transfer for this bridge
//   hwrite, haddr      address-phase direction and address
//   hwdata             write data, valid the cycle after acceptance
//   sel_in             one-hot slave decode of haddr (address phase)
//   hready_out, hresp  AHB ready / ERROR response
//   hrdata             read data to AHB (prdata while ACCESS completes, else 0)
//   psel, penable, pwrite, paddr, pwdata   registered APB outputs
//   prdata, pready, pslverr                APB slave inputs
module apb_fsm_controller #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSEL    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   sel_in,
  output logic              hready_out,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [NSEL-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A zero TIMEOUT disables the counter; keep it one bit wide so it stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt;

  // Pending transfer captured at acceptance (used when a write leaves WWAIT).
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [NSEL-1:0]   sel_q;

  // Values loaded into the APB address/control registers on entry to SETUP.
  // SETUP is entered either straight from an accept (reads) or from WWAIT,
  // where hready_out is low and no accept can happen.
  logic [ADDR_W-1:0] setup_addr;
  logic              setup_write;
  logic [NSEL-1:0]   setup_sel;

  // Where an accepted transfer goes next.
  function automatic state_t accept_target(input logic [NSEL-1:0] sel,
                                           input logic            write);
    state_t t;
    if (sel == '0)  t = ERR1;
    else if (write) t = WWAIT;
    else            t = SETUP;
    return t;
  endfunction

  assign accept      = valid && hready_out;
  assign timeout_hit = (TIMEOUT > 0) && (cnt == TO_LAST);

  assign setup_addr  = accept ? haddr  : addr_q;
  assign setup_write = accept ? hwrite : write_q;
  assign setup_sel   = accept ? sel_in : sel_q;

  assign hrdata = ((state == ACCESS) && pready) ? prdata : '0;

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= next_state;
  end

  // AHB-side outputs decoded from state
  always_comb begin
    hready_out = 1'b1;
    hresp      = 1'b0;
    unique case (state)
      IDLE:    hready_out = 1'b1;
      WWAIT:   hready_out = 1'b0;
      SETUP:   hready_out = 1'b0;
      ACCESS:  hready_out = pready && !pslverr;
      ERR1: begin
        hready_out = 1'b0;
        hresp      = 1'b1;
      end
      ERR2: begin
        hready_out = 1'b1;
        hresp      = 1'b1;
      end
      default: hready_out = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (accept) next_state = accept_target(sel_in, hwrite);
      WWAIT:  next_state = SETUP;
      SETUP:  next_state = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (pslverr)     next_state = ERR1;
          else if (accept) next_state = accept_target(sel_in, hwrite);
          else             next_state = IDLE;
        end else if (timeout_hit) begin
          next_state = ERR1;
        end
      end
      ERR1:   next_state = ERR2;
      ERR2:   next_state = accept ? accept_target(sel_in, hwrite) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pending transfer registers (datapath, no reset needed)
  always_ff @(posedge hclk) begin
    if (accept) begin
      addr_q  <= haddr;
      write_q <= hwrite;
      sel_q   <= sel_in;
    end
  end

  // APB outputs, registered from the upcoming state so they change on the
  // same edge the FSM enters SETUP / ACCESS / anything else.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      penable <= (next_state == ACCESS);
      if (next_state == SETUP) begin
        psel   <= setup_sel;
        paddr  <= setup_addr;
        pwrite <= setup_write;
      end else if (next_state != ACCESS) begin
        psel   <= '0;
      end
      // hwdata is valid in the data phase, which is the WWAIT cycle.
      if (state == WWAIT) pwdata <= hwdata;
    end
  end

  // Wait-state counter: cleared in SETUP, counts pready-low ACCESS cycles.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if ((state == ACCESS) && !pready && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller (instantiated with TIMEOUT=4).
module tb_apb_fsm_controller;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  sel_in;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  apb_fsm_controller #(
    .ADDR_W(32), .DATA_W(32), .NSEL(3), .TIMEOUT(4)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .sel_in(sel_in),
    .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge hclk);
    checks++;
    if ({psel, penable, pwrite, hresp, hready_out} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000001", {psel, penable, pwrite, hresp, hready_out});
    end
    checks++;
    if ({paddr, pwdata, hrdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {paddr, pwdata, hrdata});
    end
    #1 hresetn = 1'b1;
  endtask

  task automatic test_read();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h10; sel_in = 3'b010; pready = 1; prdata = 32'h5A;
    @(negedge hclk);
    checks++;
    if (hready_out !== 1'b1) begin errors++; $display("FAIL rd_idle_ready got %b exp 1", hready_out); end
    next_cycle();  // SETUP
    valid = 0;
    @(negedge hclk);
    checks++;
    if ({psel, penable, pwrite, hready_out} !== 6'b010000 || paddr !== 32'h10) begin
      errors++;
      $display("FAIL rd_setup got %b/%h exp 010000/10", {psel, penable, pwrite, hready_out}, paddr);
    end
    next_cycle();  // ACCESS
    @(negedge hclk);
    checks++;
    if ({penable, hready_out, hresp} !== 3'b110 || hrdata !== 32'h5A) begin
      errors++;
      $display("FAIL rd_access got %b/%h exp 110/5a", {penable, hready_out, hresp}, hrdata);
    end
    next_cycle();  // IDLE
    @(negedge hclk);
    checks++;
    if ({psel, penable, hready_out} !== 5'b00001) begin
      errors++;
      $display("FAIL rd_done got %b exp 00001", {psel, penable, hready_out});
    end
  endtask

  task automatic test_write();
    next_cycle();
    valid = 1; hwrite = 1; haddr = 32'h20; sel_in = 3'b001; pready = 1;
    next_cycle();  // WWAIT
    valid = 0; hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    checks++;
    if ({psel, penable, hready_out} !== 5'b00000) begin
      errors++;
      $display("FAIL wr_wwait got %b exp 00000", {psel, penable, hready_out});
    end
    next_cycle();  // SETUP
    hwdata = 32'h0;
    @(negedge hclk);
    checks++;
    if (pwdata !== 32'hDEAD_BEEF || paddr !== 32'h20 || {psel, penable, pwrite} !== 5'b00101) begin
      errors++;
      $display("FAIL wr_setup got %h/%h/%b exp deadbeef/20/00101", pwdata, paddr, {psel, penable, pwrite});
    end
    next_cycle();  // ACCESS
    @(negedge hclk);
    checks++;
    if ({penable, hready_out, hresp} !== 3'b110) begin
      errors++;
      $display("FAIL wr_access got %b exp 110", {penable, hready_out, hresp});
    end
    next_cycle();  // IDLE
  endtask

  task automatic test_wait_states();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h30; sel_in = 3'b100; pready = 0; prdata = 32'h77;
    next_cycle();  // SETUP
    valid = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();  // ACCESS, stalled
      @(negedge hclk);
      checks++;
      if ({psel, penable, hready_out} !== 5'b10010 || paddr !== 32'h30 || hrdata !== 32'h0) begin
        errors++;
        $display("FAIL ws_stall%0d got %b/%h/%h exp 10010/30/0", i, {psel, penable, hready_out}, paddr, hrdata);
      end
    end
    next_cycle();  // fourth ACCESS cycle
    pready = 1;
    @(negedge hclk);
    checks++;
    if ({psel, penable, hready_out} !== 5'b10011 || hrdata !== 32'h77) begin
      errors++;
      $display("FAIL ws_done got %b/%h exp 10011/77", {psel, penable, hready_out}, hrdata);
    end
    next_cycle();  // IDLE
  endtask

  task automatic test_slverr();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h44; sel_in = 3'b010; pready = 1; pslverr = 1;
    next_cycle();  // SETUP
    valid = 0;
    next_cycle();  // ACCESS
    @(negedge hclk);
    checks++;
    if ({hready_out, hresp} !== 2'b00) begin
      errors++;
      $display("FAIL err_access got %b exp 00", {hready_out, hresp});
    end
    next_cycle();  // ERR1
    pslverr = 0;
    @(negedge hclk);
    checks++;
    if ({psel, penable, hresp, hready_out} !== 6'b000010) begin
      errors++;
      $display("FAIL err_err1 got %b exp 000010", {psel, penable, hresp, hready_out});
    end
    next_cycle();  // ERR2
    @(negedge hclk);
    checks++;
    if ({psel, penable, hresp, hready_out} !== 6'b000011) begin
      errors++;
      $display("FAIL err_err2 got %b exp 000011", {psel, penable, hresp, hready_out});
    end
  endtask

  task automatic test_timeout();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h60; sel_in = 3'b001; pready = 0;
    next_cycle();  // SETUP
    valid = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();  // ACCESS
      @(negedge hclk);
      checks++;
      if ({penable, hready_out, hresp} !== 3'b100) begin
        errors++;
        $display("FAIL to_access%0d got %b exp 100", i, {penable, hready_out, hresp});
      end
    end
    next_cycle();  // ERR1
    @(negedge hclk);
    checks++;
    if ({psel, penable, hresp, hready_out} !== 6'b000010) begin
      errors++;
      $display("FAIL to_err1 got %b exp 000010", {psel, penable, hresp, hready_out});
    end
    next_cycle();  // ERR2
    pready = 1;
    @(negedge hclk);
    checks++;
    if ({hresp, hready_out} !== 2'b11) begin
      errors++;
      $display("FAIL to_err2 got %b exp 11", {hresp, hready_out});
    end
  endtask

  task automatic test_no_sel();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h70; sel_in = 3'b000; pready = 1;
    next_cycle();  // ERR1
    valid = 0;
    @(negedge hclk);
    checks++;
    if ({psel, penable, hresp, hready_out} !== 6'b000010) begin
      errors++;
      $display("FAIL nosel_err1 got %b exp 000010", {psel, penable, hresp, hready_out});
    end
    next_cycle();  // ERR2
    @(negedge hclk);
    checks++;
    if ({psel, penable, hresp, hready_out} !== 6'b000011) begin
      errors++;
      $display("FAIL nosel_err2 got %b exp 000011", {psel, penable, hresp, hready_out});
    end
    next_cycle();  // IDLE
    @(negedge hclk);
    checks++;
    if ({psel, hresp, hready_out} !== 5'b00001) begin
      errors++;
      $display("FAIL nosel_idle got %b exp 00001", {psel, hresp, hready_out});
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h80; sel_in = 3'b100; pready = 1; prdata = 32'h99;
    next_cycle();  // SETUP
    valid = 0;
    next_cycle();  // ACCESS, completes; new write offered
    valid = 1; hwrite = 1; haddr = 32'h40; sel_in = 3'b001;
    @(negedge hclk);
    checks++;
    if (hready_out !== 1'b1 || hrdata !== 32'h99) begin
      errors++;
      $display("FAIL b2b_access got %b/%h exp 1/99", hready_out, hrdata);
    end
    next_cycle();  // WWAIT, no IDLE gap
    valid = 0; hwdata = 32'h1234_5678;
    @(negedge hclk);
    checks++;
    if ({psel, penable, hready_out} !== 5'b00000) begin
      errors++;
      $display("FAIL b2b_wwait got %b exp 00000", {psel, penable, hready_out});
    end
    next_cycle();  // SETUP
    @(negedge hclk);
    checks++;
    if (pwdata !== 32'h1234_5678 || paddr !== 32'h40 || {psel, penable, pwrite} !== 5'b00101) begin
      errors++;
      $display("FAIL b2b_setup got %h/%h/%b exp 12345678/40/00101", pwdata, paddr, {psel, penable, pwrite});
    end
    next_cycle();  // ACCESS
    @(negedge hclk);
    checks++;
    if ({penable, hready_out} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_wr_access got %b exp 11", {penable, hready_out});
    end
    next_cycle();  // IDLE
  endtask

  task automatic test_reset_mid();
    next_cycle();
    valid = 1; hwrite = 0; haddr = 32'h50; sel_in = 3'b010; pready = 0;
    next_cycle();  // SETUP
    valid = 0;
    next_cycle();  // ACCESS
    @(negedge hclk);
    checks++;
    if (penable !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", penable); end
    #1 hresetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite, hresp, hready_out} !== 7'b0000001 || paddr !== 32'h0 || pwdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid got %b/%h/%h exp 0000001/0/0", {psel, penable, pwrite, hresp, hready_out}, paddr, pwdata);
    end
    #1 hresetn = 1'b1;
    pready = 1;
    next_cycle();
    @(negedge hclk);
    checks++;
    if ({psel, penable, hresp, hready_out} !== 6'b000001) begin
      errors++;
      $display("FAIL rst_after got %b exp 000001", {psel, penable, hresp, hready_out});
    end
  endtask

  initial begin
    hresetn = 0; valid = 0; hwrite = 0; haddr = '0; hwdata = '0; sel_in = '0;
    prdata = '0; pready = 0; pslverr = 0;
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_slverr();
    test_read();
    test_timeout();
    test_no_sel();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
